// File: rtl/p32b_8b_pkg.sv
// ============================================================================
// p32b_8b_pkg : shared constants and byte-select helper for the serializer
// Rev 1.0
// ============================================================================
`default_nettype none

package p32b_8b_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int PHASE_W        = 2;
  localparam logic [7:0] IDLE_BYTE = 8'h00;
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(BYTES_PER_WORD - 1);

  // Byte emitted at position idx of a word, honouring the configured order.
  function automatic logic [7:0] pick_byte(input logic [31:0] word,
                                           input logic [PHASE_W-1:0] idx,
                                           input logic msb_first);
    logic [PHASE_W-1:0] sel;
    sel = msb_first ? (LAST_PHASE - idx) : idx;
    pick_byte = word[{sel, 3'b000} +: 8];
  endfunction

endpackage

`default_nettype wire

// File: rtl/p32b_8b_hold.sv
// ============================================================================
// p32b_8b_hold : one-entry holding register decoupling producer and shifter
// Rev 1.0
// ============================================================================
`default_nettype none

module p32b_8b_hold
  import p32b_8b_pkg::*;
(
  input  logic        clk_4f,
  input  logic        reset_L,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] data_in,
  output logic [31:0] hold_word,
  output logic        hold_v,
  output logic        ready_out
);

  logic [31:0] hold_q, hold_d;
  logic        hold_v_q, hold_v_d;

  // A push on the same edge as a pop keeps the entry occupied.
  always_comb begin
    hold_d   = push ? data_in : hold_q;
    hold_v_d = push | (hold_v_q & ~pop);
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      hold_q   <= 32'h0;
      hold_v_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
    end
  end

  assign hold_word = hold_q;
  assign hold_v    = hold_v_q;
  assign ready_out = ~hold_v_q;

endmodule

`default_nettype wire

// File: rtl/p32b_8b.sv
// ============================================================================
// p32b_8b : 32-bit word to 8-bit byte serializer with valid/ready input
// Rev 1.0
// ============================================================================
`default_nettype none

module p32b_8b
  import p32b_8b_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk_4f,
  input  logic        reset_L,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [7:0]  data_out,
  output logic        valid_out
);

  logic [31:0]        sh_q, sh_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               busy_q, busy_d;
  logic [7:0]         data_out_q, data_out_d;
  logic               valid_out_q, valid_out_d;

  logic               hold_v;
  logic [31:0]        hold_word;
  logic               hs;
  logic               load;
  logic               take_hold;
  logic               take_in;
  logic               push;
  logic [31:0]        src;
  logic [PHASE_W-1:0] next_phase;

  assign hs         = valid_in & ready_out;
  assign load       = ~busy_q | (phase_q == LAST_PHASE);
  assign take_hold  = load & hold_v;
  assign take_in    = load & ~hold_v & hs;
  // Accepted words that cannot go straight to the shifter wait in hold.
  assign push       = hs & ~take_in;
  assign src        = hold_v ? hold_word : data_in;
  assign next_phase = phase_q + 1'b1;

  p32b_8b_hold u_hold (
    .clk_4f    (clk_4f),
    .reset_L   (reset_L),
    .push      (push),
    .pop       (take_hold),
    .data_in   (data_in),
    .hold_word (hold_word),
    .hold_v    (hold_v),
    .ready_out (ready_out)
  );

  always_comb begin
    sh_d        = sh_q;
    phase_d     = phase_q;
    busy_d      = busy_q;
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    if (load) begin
      if (take_hold || take_in) begin
        sh_d        = src;
        phase_d     = '0;
        busy_d      = 1'b1;
        data_out_d  = pick_byte(src, '0, MSB_FIRST);
        valid_out_d = 1'b1;
      end else begin
        busy_d      = 1'b0;
        valid_out_d = 1'b0;
        data_out_d  = IDLE_BYTE;
      end
    end else begin
      phase_d     = next_phase;
      data_out_d  = pick_byte(sh_q, next_phase, MSB_FIRST);
      valid_out_d = 1'b1;
    end
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      sh_q        <= 32'h0;
      phase_q     <= '0;
      busy_q      <= 1'b0;
      data_out_q  <= IDLE_BYTE;
      valid_out_q <= 1'b0;
    end else begin
      sh_q        <= sh_d;
      phase_q     <= phase_d;
      busy_q      <= busy_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;

endmodule

`default_nettype wire
